// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: merges the FLU/LOAD/STORE/FPU result streams from the
// execute stage onto NR_WB_PORTS scoreboard writeback ports. Each source has
// a small FIFO because the execute stage cannot be stalled on its results.
// A round-robin scan starting at rr_q drains the FIFOs onto the ports.
//
// Optional feature macro: WB_RESULT_BYPASS_EN
//   defined   - a valid input that finds its FIFO empty can be granted in the
//               same cycle (zero latency) and is then not stored.
//   undefined - every result is registered first (one cycle latency).
module wb_result_arbiter #(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned NR_WB_PORTS   = 2,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned EX_BITS       = 129
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic [3:0]                                res_valid_i,
    input  logic [3:0][TRANS_ID_BITS-1:0]             res_trans_id_i,
    input  logic [3:0][XLEN-1:0]                      res_data_i,
    input  logic [3:0][EX_BITS-1:0]                   res_ex_i,
    input  logic                                      wb_ready_i,
    output logic [NR_WB_PORTS-1:0]                    wb_valid_o,
    output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_data_o,
    output logic [NR_WB_PORTS-1:0][EX_BITS-1:0]       wb_ex_o,
    output logic [3:0]                                fu_stall_o,
    output logic                                      overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [XLEN-1:0]          data;
        logic [EX_BITS-1:0]       ex;
    } entry_t;

    // Writeback only happens when the scoreboard accepts and no flush is active.
    logic fire;
    assign fire = wb_ready_i & ~flush_i;

    entry_t [3:0]                in_ent;
    entry_t [3:0]                head;
    entry_t [3:0]                cand;
    logic   [3:0]                nonempty;
    logic   [3:0]                eligible;
    logic   [3:0]                grant;
    logic   [3:0]                drop;
    logic   [3:0][CNT_W-1:0]     count;

    logic   [1:0]                rr_q;
    logic   [1:0]                last_src;
    logic   [1:0]                scan_src;
    logic                        any_grant;
    int                          n_granted;
    logic   [NR_WB_PORTS-1:0]    port_vld;
    entry_t [NR_WB_PORTS-1:0]    port_ent;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_src
            logic [PTR_W-1:0] rd_ptr_q;
            logic [PTR_W-1:0] wr_ptr_q;
            logic [CNT_W-1:0] count_q;
            entry_t           mem_q [DEPTH];
            logic             pop;
            logic             byp;
            logic             push_req;
            logic             full;
            logic             push;

            assign in_ent[gi]   = {res_trans_id_i[gi], res_data_i[gi], res_ex_i[gi]};
            assign count[gi]    = count_q;
            assign nonempty[gi] = (count_q != '0);
            assign head[gi]     = mem_q[rd_ptr_q];

`ifdef WB_RESULT_BYPASS_EN
            // An empty FIFO lets a fresh input compete directly for a port.
            assign eligible[gi] = nonempty[gi] | res_valid_i[gi];
            assign cand[gi]     = nonempty[gi] ? head[gi] : in_ent[gi];
`else
            assign eligible[gi] = nonempty[gi];
            assign cand[gi]     = head[gi];
`endif

            // A grant pops the head, or (bypass only) consumes the input.
            assign pop      = grant[gi] & fire & nonempty[gi];
            assign byp      = grant[gi] & fire & ~nonempty[gi];
            assign push_req = res_valid_i[gi] & ~flush_i & ~byp;
            assign full     = (count_q == CNT_W'(DEPTH));
            assign push     = push_req & (~full | pop);
            assign drop[gi] = push_req & full & ~pop;

            assign fu_stall_o[gi] = (count_q >= CNT_W'(DEPTH - 1));

            // Pointer and occupancy bookkeeping; flush empties the FIFO.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    count_q  <= '0;
                end else if (flush_i) begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
                end
            end

            // Entry storage; contents are only meaningful below count_q.
            always_ff @(posedge clk_i) begin
                if (push) mem_q[wr_ptr_q] <= in_ent[gi];
            end
        end
    endgenerate

    // Round-robin scan from rr_q: the k-th eligible source lands on port k.
    always_comb begin
        grant     = '0;
        port_vld  = '0;
        port_ent  = '0;
        last_src  = rr_q;
        scan_src  = rr_q;
        any_grant = 1'b0;
        n_granted = 0;
        for (int i = 0; i < 4; i++) begin
            scan_src = rr_q + 2'(i);
            if (eligible[scan_src] && (n_granted < int'(NR_WB_PORTS))) begin
                grant[scan_src] = 1'b1;
                last_src        = scan_src;
                any_grant       = 1'b1;
                for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
                    if (p == n_granted) begin
                        port_vld[p] = 1'b1;
                        port_ent[p] = cand[scan_src];
                    end
                end
                n_granted = n_granted + 1;
            end
        end
    end

    generate
        for (gi = 0; gi < int'(NR_WB_PORTS); gi++) begin : g_port
            assign wb_valid_o[gi]    = port_vld[gi] & fire;
            assign wb_trans_id_o[gi] = wb_valid_o[gi] ? port_ent[gi].id   : '0;
            assign wb_data_o[gi]     = wb_valid_o[gi] ? port_ent[gi].data : '0;
            assign wb_ex_o[gi]       = wb_valid_o[gi] ? port_ent[gi].ex   : '0;
        end
    endgenerate

    // Pointer advances past the last granted source; flush restarts at FLU.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 2'd0;
        end else if (flush_i) begin
            rr_q <= 2'd0;
        end else if (fire && any_grant) begin
            rr_q <= last_src + 2'd1;
        end
    end

    // Sticky drop indicator; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
        end else if (|drop) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter (DEPTH=2, NR_WB_PORTS=2).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the edge, well before the next one.
module tb_wb_result_arbiter;

    localparam int TID = 3;
    localparam int XL  = 64;
    localparam int EXB = 129;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     flush_i;
    logic [3:0]               res_valid_i;
    logic [3:0][TID-1:0]      res_trans_id_i;
    logic [3:0][XL-1:0]       res_data_i;
    logic [3:0][EXB-1:0]      res_ex_i;
    logic                     wb_ready_i;
    logic [1:0]               wb_valid_o;
    logic [1:0][TID-1:0]      wb_trans_id_o;
    logic [1:0][XL-1:0]       wb_data_o;
    logic [1:0][EXB-1:0]      wb_ex_o;
    logic [3:0]               fu_stall_o;
    logic                     overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    wb_result_arbiter #(
        .DEPTH(2), .NR_WB_PORTS(2), .TRANS_ID_BITS(TID), .XLEN(XL), .EX_BITS(EXB)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .res_valid_i    (res_valid_i),
        .res_trans_id_i (res_trans_id_i),
        .res_data_i     (res_data_i),
        .res_ex_i       (res_ex_i),
        .wb_ready_i     (wb_ready_i),
        .wb_valid_o     (wb_valid_o),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_data_o      (wb_data_o),
        .wb_ex_o        (wb_ex_o),
        .fu_stall_o     (fu_stall_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in();
        res_valid_i    = '0;
        res_trans_id_i = '0;
        res_data_i     = '0;
        res_ex_i       = '0;
        flush_i        = 1'b0;
    endtask

    task automatic drive(input int src, input logic [TID-1:0] id, input logic [XL-1:0] data);
        res_valid_i[src]    = 1'b1;
        res_trans_id_i[src] = id;
        res_data_i[src]     = data;
    endtask

    initial begin
        rst_ni     = 1'b0;
        wb_ready_i = 1'b1;
        clr_in();
        nxt();
        nxt();
        #1;
        chk("rst_valid",  wb_valid_o, 2'b00);
        chk("rst_data",   wb_data_o, '0);
        chk("rst_id",     wb_trans_id_o, '0);
        chk("rst_stall",  fu_stall_o, 4'b0000);
        chk("rst_ovf",    overflow_o, 1'b0);
        rst_ni = 1'b1;

`ifdef WB_RESULT_BYPASS_EN
        // FPU result with empty FIFO: same-cycle writeback, nothing stored.
        nxt();
        drive(3, 3'd5, 64'hCD);
        #1;
        chk("byp_valid", wb_valid_o, 2'b01);
        chk("byp_id",    wb_trans_id_o[0], 3'd5);
        chk("byp_data",  wb_data_o[0], 64'hCD);
        nxt();
        clr_in();
        #1;
        chk("byp_after", wb_valid_o, 2'b00);
        chk("byp_stall", fu_stall_o, 4'b0000);
        // Not ready: the result is stored and shows up once ready returns.
        nxt();
        wb_ready_i = 1'b0;
        drive(3, 3'd6, 64'hEE);
        #1;
        chk("byp_nrdy", wb_valid_o, 2'b00);
        nxt();
        clr_in();
        wb_ready_i = 1'b1;
        #1;
        chk("byp_st_vld", wb_valid_o, 2'b01);
        chk("byp_st_id",  wb_trans_id_o[0], 3'd6);
        nxt();
        #1;
        chk("byp_empty", wb_valid_o, 2'b00);
`else
        // Single FLU result: appears one cycle later with its exception intact.
        nxt();
        drive(0, 3'd3, 64'hAB);
        res_ex_i[0] = 129'h1_0000_0000_0000_0005_0000_0000_0000_0002;
        #1;
        chk("t1_same_cyc", wb_valid_o, 2'b00);
        nxt();
        clr_in();
        #1;
        chk("t1_valid", wb_valid_o, 2'b01);
        chk("t1_id",    wb_trans_id_o[0], 3'd3);
        chk("t1_data",  wb_data_o[0], 64'hAB);
        chk("t1_ex",    wb_ex_o[0], 129'h1_0000_0000_0000_0005_0000_0000_0000_0002);
        nxt();
        #1;
        chk("t1_drained", wb_valid_o, 2'b00);

        // Flush with empty FIFOs to bring rr back to 0.
        flush_i = 1'b1;
        nxt();
        clr_in();

        // All four sources at once: FLU+LOAD first, then STORE+FPU.
        for (int s = 0; s < 4; s++) drive(s, 3'(4 + s), 64'(16 + s));
        nxt();
        clr_in();
        #1;
        chk("t2_vld_a", wb_valid_o, 2'b11);
        chk("t2_p0_a",  wb_trans_id_o[0], 3'd4);
        chk("t2_p1_a",  wb_trans_id_o[1], 3'd5);
        chk("t2_d1_a",  wb_data_o[1], 64'h11);
        nxt();
        #1;
        chk("t2_vld_b", wb_valid_o, 2'b11);
        chk("t2_p0_b",  wb_trans_id_o[0], 3'd6);
        chk("t2_p1_b",  wb_trans_id_o[1], 3'd7);
        nxt();
        // rr must be back at 0: FLU wins port 0 over FPU.
        drive(0, 3'd1, 64'h1);
        drive(3, 3'd2, 64'h2);
        nxt();
        clr_in();
        #1;
        chk("t2_rr_p0", wb_trans_id_o[0], 3'd1);
        chk("t2_rr_p1", wb_trans_id_o[1], 3'd2);
        nxt();

        // Full FIFO with simultaneous push and pop: no drop, order kept.
        wb_ready_i = 1'b0;
        drive(1, 3'd1, 64'h0);
        nxt();
        drive(1, 3'd2, 64'h0);
        nxt();
        wb_ready_i = 1'b1;
        drive(1, 3'd3, 64'h0);
        #1;
        chk("t4_id1",   wb_trans_id_o[0], 3'd1);
        chk("t4_stall", fu_stall_o, 4'b0010);
        nxt();
        drive(1, 3'd4, 64'h0);
        #1;
        chk("t4_id2",   wb_trans_id_o[0], 3'd2);
        nxt();
        clr_in();
        #1;
        chk("t4_id3",   wb_trans_id_o[0], 3'd3);
        chk("t4_stl3",  fu_stall_o, 4'b0010);
        nxt();
        #1;
        chk("t4_id4",   wb_trans_id_o[0], 3'd4);
        chk("t4_p1",    wb_valid_o[1], 1'b0);
        nxt();
        #1;
        chk("t4_empty", wb_valid_o, 2'b00);
        chk("t4_ovf",   overflow_o, 1'b0);
        chk("t4_nostl", fu_stall_o, 4'b0000);

        // Not ready, LOAD pushed three times: third is dropped.
        wb_ready_i = 1'b0;
        drive(1, 3'd1, 64'h0);
        nxt();
        drive(1, 3'd2, 64'h0);
        #1;
        chk("t3_stall1", fu_stall_o[1], 1'b1);
        chk("t3_ovf0",   overflow_o, 1'b0);
        chk("t3_novld",  wb_valid_o, 2'b00);
        nxt();
        drive(1, 3'd3, 64'h0);
        nxt();
        clr_in();
        wb_ready_i = 1'b1;
        #1;
        chk("t3_ovf1",  overflow_o, 1'b1);
        chk("t3_id1",   wb_trans_id_o[0], 3'd1);
        nxt();
        #1;
        chk("t3_id2",   wb_trans_id_o[0], 3'd2);
        chk("t3_vld2",  wb_valid_o, 2'b01);
        nxt();
        #1;
        chk("t3_empty", wb_valid_o, 2'b00);
        chk("t3_sticky", overflow_o, 1'b1);

        // Flush with FLU and STORE holding entries.
        wb_ready_i = 1'b0;
        drive(0, 3'd5, 64'h0);
        drive(2, 3'd6, 64'h0);
        nxt();
        clr_in();
        #1;
        chk("t5_stall", fu_stall_o, 4'b0101);
        nxt();
        flush_i    = 1'b1;
        wb_ready_i = 1'b1;
        drive(3, 3'd7, 64'h0);
        #1;
        chk("t5_flushcyc", wb_valid_o, 2'b00);
        nxt();
        clr_in();
        #1;
        chk("t5_vld",   wb_valid_o, 2'b00);
        chk("t5_stl",   fu_stall_o, 4'b0000);
        chk("t5_ovf",   overflow_o, 1'b1);
        // rr restarted at 0: LOAD and STORE win before FPU.
        drive(1, 3'd1, 64'h0);
        drive(2, 3'd2, 64'h0);
        drive(3, 3'd3, 64'h0);
        nxt();
        clr_in();
        #1;
        chk("t5_rr_p0", wb_trans_id_o[0], 3'd1);
        chk("t5_rr_p1", wb_trans_id_o[1], 3'd2);
        nxt();
        #1;
        chk("t5_fpu",   wb_trans_id_o[0], 3'd3);
        chk("t5_fpuv",  wb_valid_o, 2'b01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_result_arbiter.md
# wb_result_arbiter

Collects the result streams leaving the execute stage (FLU, load, store and FPU) and merges them onto a fixed number of scoreboard writeback ports. The execute stage has no backpressure on its result outputs, so each source gets a small per-source FIFO. A round-robin arbiter drains the FIFOs into the writeback ports. The block sits between `ex_stage` and the scoreboard; its stall outputs feed the issue stage so it stops issuing to a functional unit whose FIFO is nearly full.

## Interface

**Parameters**
- `DEPTH`, default 2: entries per source FIFO, power of two, ≥ 2.
- `NR_WB_PORTS`, default 2: number of writeback ports, 1..4.

**Ports**
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `flush_i`, input, 1: pipeline flush.
- `res_valid_i`, input, [3:0]: result valid per source; 0=FLU, 1=LOAD, 2=STORE, 3=FPU.
- `res_trans_id_i`, input, [3:0][TRANS_ID_BITS-1:0]: scoreboard ID per source.
- `res_data_i`, input, [3:0] riscv::xlen_t: result per source.
- `res_ex_i`, input, [3:0] exception_t: exception per source.
- `wb_ready_i`, input, 1: scoreboard accepts writebacks this cycle.
- `wb_valid_o`, output, [NR_WB_PORTS-1:0]: writeback valid.
- `wb_trans_id_o`, output, [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]: writeback ID.
- `wb_data_o`, output, [NR_WB_PORTS-1:0] riscv::xlen_t: writeback data.
- `wb_ex_o`, output, [NR_WB_PORTS-1:0] exception_t: writeback exception.
- `fu_stall_o`, output, [3:0]: source FIFO occupancy ≥ DEPTH-1.
- `overflow_o`, output, 1: sticky; a push was dropped.

## Operation

**FIFOs**
- One FIFO per source, with `clog2(DEPTH)`-bit read and write pointers that wrap at DEPTH and a `clog2(DEPTH)+1`-bit count.
- A valid input is pushed unless it was consumed by bypass (see Configuration).
- Push and pop in the same cycle are both allowed when the FIFO is full; the count is unchanged.
- Push to a full FIFO with no pop in that cycle: the entry is dropped and `overflow_o` is set to 1. It clears only on reset.

**Arbitration**
- A source is eligible when its FIFO is non-empty, or when bypass is enabled and `res_valid_i` is set with an empty FIFO.
- When `wb_ready_i`=1, grant up to NR_WB_PORTS distinct eligible sources. Scan from round-robin pointer `rr` upward, mod 4.
- The k-th grant drives writeback port k. Ports with no grant drive valid=0, and their data, ID and exception are 0.
- Each grant pops the head entry of its FIFO. With bypass, the grant consumes the input instead.
- `rr` moves to one past the last granted source. If there was no grant, `rr` is unchanged.
- When `wb_ready_i`=0: nothing pops, all `wb_valid_o`=0, and `rr` holds.

**Flush**
- All FIFO pointers and counts are cleared and `rr` is set to 0.
- `wb_valid_o` is forced to 0 in the flush cycle, and inputs in the flush cycle are discarded.
- `overflow_o` is not affected by flush.

**Ordering and exceptions**
- Order is preserved within a source. There is no ordering guarantee across sources.
- Exception fields pass through unchanged.

## Timing

- Reset values: `wb_valid_o`=0, `wb_trans_id_o`/`wb_data_o`/`wb_ex_o`=0, `fu_stall_o`=0, `overflow_o`=0, `rr`=0, all FIFOs empty.
- Outputs are combinational from FIFO heads, `rr` and `wb_ready_i`. FIFO state updates on the rising edge.
- Latency without bypass: a result presented in cycle N appears on `wb_*` no earlier than cycle N+1.
- `fu_stall_o` reflects the registered count and is visible in the cycle after the push.

## Configuration

- Macro `WB_RESULT_BYPASS_EN`.
- Defined: an eligible source with an empty FIFO and a valid input that wins a grant appears on the writeback port in the same cycle (latency 0) and is not stored.
- Not defined: every result is registered first (latency 1), and `wb_*` depends on `wb_ready_i` only through the valid gating.

## Test plan

- **Reset then idle, no bypass:** all outputs 0; `res_valid_i`=4'b0001, ID=3, data=0xAB → cycle+1: `wb_valid_o`[0]=1, ID=3, data=0xAB.
- **All four sources valid at once, NR_WB_PORTS=2, `rr`=0:** grant order is FLU+LOAD, then STORE+FPU in the next cycle; `rr` goes 0→2→0.
- **`wb_ready_i`=0 with LOAD pushed each cycle, DEPTH=2:**
  - `fu_stall_o`[1]=1 after the first push.
  - The third push is dropped and `overflow_o`=1 stays set.
  - FIFO content is the first two IDs, in order.
- **Simultaneous full push and pop:** count stays at 2, no overflow, and the output ID sequence is preserved.
- **flush_i with two FIFOs non-empty:** next cycle all `wb_valid_o`=0, counts 0, `rr`=0, and `overflow_o` unchanged.
- **With `WB_RESULT_BYPASS_EN`:** an FPU result with an empty FIFO and `wb_ready_i`=1 appears on `wb_valid_o`[0] in the same cycle, and FIFO[3] stays empty.
